// File: rtl/pi_txn_queue_if.sv
// Handshake and status bundle between the Pi write decoder, the command queue
// and the M68K bus engine. The queue itself connects through the slave modport.
interface pi_txn_queue_if #(
  parameter int unsigned DEPTH = 4
) ();
  localparam int unsigned AW = $clog2(DEPTH);

  logic        wr_stb;
  logic [1:0]  wr_sa;
  logic [15:0] wr_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [23:0] cmd_addr;
  logic [15:0] cmd_data;
  logic        cmd_rw;
  logic        cmd_uds_n;
  logic        cmd_lds_n;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic [15:0] rd_data;
  logic        txn_busy;
  logic [AW:0] fifo_count;
  logic        err;

  modport master (
    output wr_stb, wr_sa, wr_data, cmd_ready, rsp_valid, rsp_data,
    input  cmd_valid, cmd_addr, cmd_data, cmd_rw, cmd_uds_n, cmd_lds_n,
    input  rd_data, txn_busy, fifo_count, err
  );

  modport slave (
    input  wr_stb, wr_sa, wr_data, cmd_ready, rsp_valid, rsp_data,
    output cmd_valid, cmd_addr, cmd_data, cmd_rw, cmd_uds_n, cmd_lds_n,
    output rd_data, txn_busy, fifo_count, err
  );
endinterface

// File: rtl/pi_txn_queue.sv
// Command queue between the Pi register-write decoder and the M68K bus engine:
// assembles bus commands from register writes, buffers them, and tracks one read.
module pi_txn_queue #(
  parameter int unsigned DEPTH = 4
) (
  input logic           c125m,
  input logic           rst,
  pi_txn_queue_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  typedef struct packed {
    logic [23:0] addr;
    logic [15:0] data;
    logic        rw;
    logic        byte_sel;
  } entry_t;

  entry_t      mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
  logic [AW:0] count, count_d;
  logic [15:0] data_hold_q, addr_lo_hold_q, rd_data_q;
  logic        rd_pending_q, rd_pending_d, err_q, busy_q;

  entry_t      head, new_entry;
  logic        empty, pop, push_req, push_rw, pend_after_rsp, push_ok;

  always_comb begin
    count          = wr_ptr_q - rd_ptr_q;
    empty          = (count == '0);
    head           = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    pop            = !empty && bus.cmd_ready;
    push_req       = bus.wr_stb && (bus.wr_sa == 2'd2);
    push_rw        = bus.wr_data[9];
    // A response in the same cycle retires the old read before a new one is judged.
    pend_after_rsp = rd_pending_q && !bus.rsp_valid;
    push_ok        = push_req && ((count != FullCount) || pop) && !(push_rw && pend_after_rsp);
    new_entry      = '{addr:     {bus.wr_data[7:0], addr_lo_hold_q},
                       data:     data_hold_q,
                       rw:       push_rw,
                       byte_sel: bus.wr_data[8]};
    wr_ptr_d       = wr_ptr_q + {{AW{1'b0}}, push_ok};
    rd_ptr_d       = rd_ptr_q + {{AW{1'b0}}, pop};
    count_d        = wr_ptr_d - rd_ptr_d;
    rd_pending_d   = pend_after_rsp || (push_ok && push_rw);
  end

  always_ff @(posedge c125m) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      data_hold_q    <= '0;
      addr_lo_hold_q <= '0;
      rd_data_q      <= '0;
      rd_pending_q   <= 1'b0;
      err_q          <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      rd_pending_q <= rd_pending_d;
      busy_q       <= (count_d != '0) || rd_pending_d;
      if (bus.wr_stb && (bus.wr_sa == 2'd0)) data_hold_q <= bus.wr_data;
      if (bus.wr_stb && (bus.wr_sa == 2'd1)) addr_lo_hold_q <= bus.wr_data;
      if (push_req && !push_ok) err_q <= 1'b1;
      if (bus.rsp_valid && rd_pending_q) rd_data_q <= bus.rsp_data;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the queue is empty.
  always_ff @(posedge c125m) begin
    if (push_ok && !rst) mem_q[wr_ptr_q[AW-1:0]] <= new_entry;
  end

  always_comb begin
    bus.cmd_valid  = !empty;
    bus.cmd_addr   = head.addr;
    bus.cmd_data   = head.data;
    bus.cmd_rw     = head.rw;
    bus.cmd_uds_n  = head.byte_sel & head.addr[0];
    bus.cmd_lds_n  = head.byte_sel & ~head.addr[0];
    bus.rd_data    = rd_data_q;
    bus.txn_busy   = busy_q;
    bus.fifo_count = count;
    bus.err        = err_q;
  end
endmodule

// File: tb/tb_pi_txn_queue.sv
// Randomized scoreboard bench for pi_txn_queue: a queue-based reference model
// predicts commands and status; a monitor checks every accepted command.
module tb_pi_txn_queue;
  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [23:0] addr;
    logic [15:0] data;
    logic        rw;
    logic        uds_n;
    logic        lds_n;
  } cmd_t;

  logic c125m = 1'b0;
  logic rst   = 1'b1;
  always #5 c125m = ~c125m;

  pi_txn_queue_if #(.DEPTH(DEPTH)) bus ();

  pi_txn_queue #(.DEPTH(DEPTH)) dut (
    .c125m (c125m),
    .rst   (rst),
    .bus   (bus)
  );

  int   errors = 0;
  int   checks = 0;
  cmd_t sb[$];

  // Reference model state.
  logic [15:0] m_data_hold, m_lo_hold, m_rd;
  logic        m_pend, m_err;
  int          m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    chk("fifo_count", 32'(bus.fifo_count), 32'(m_cnt));
    chk("cmd_valid", 32'(bus.cmd_valid), 32'(m_cnt != 0));
    chk("txn_busy", 32'(bus.txn_busy), 32'((m_cnt != 0) || m_pend));
    chk("err", 32'(bus.err), 32'(m_err));
    chk("rd_data", 32'(bus.rd_data), 32'(m_rd));
    if (m_cnt == 0) begin
      chk("empty_head", {7'd0, bus.cmd_uds_n, bus.cmd_addr},
          {7'd0, 1'b0, 24'd0});
      chk("empty_head_data", {14'd0, bus.cmd_lds_n, bus.cmd_rw, bus.cmd_data}, 32'd0);
    end
  endtask

  // Apply one cycle of stimulus, advance the model, then check state after the edge.
  task automatic step(input logic stb, input logic [1:0] sa, input logic [15:0] d,
                      input logic rdy, input logic rv, input logic [15:0] rdat,
                      input logic r);
    bit   pop, pend_eff, accept, rw, bsel;
    cmd_t e;
    bus.wr_stb    = stb;
    bus.wr_sa     = sa;
    bus.wr_data   = d;
    bus.cmd_ready = rdy;
    bus.rsp_valid = rv;
    bus.rsp_data  = rdat;
    rst           = r;
    if (r) begin
      m_data_hold = '0; m_lo_hold = '0; m_rd = '0; m_pend = 0; m_err = 0; m_cnt = 0;
      sb.delete();
    end else begin
      pop      = (m_cnt > 0) && rdy;
      pend_eff = m_pend && !rv;
      if (rv && m_pend) m_rd = rdat;
      accept = 0;
      rw     = d[9];
      if (stb && sa == 2'd0) m_data_hold = d;
      else if (stb && sa == 2'd1) m_lo_hold = d;
      else if (stb && sa == 2'd2) begin
        if ((m_cnt < DEPTH || pop) && !(rw && pend_eff)) begin
          accept  = 1;
          bsel    = d[8];
          e.addr  = {d[7:0], m_lo_hold};
          e.data  = m_data_hold;
          e.rw    = rw;
          e.uds_n = bsel ? e.addr[0] : 1'b0;
          e.lds_n = bsel ? !e.addr[0] : 1'b0;
          sb.push_back(e);
        end else begin
          m_err = 1;
        end
      end
      m_cnt  = m_cnt - int'(pop) + int'(accept);
      m_pend = pend_eff || (accept && rw);
    end
    @(posedge c125m);
    #1;
    check_state();
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 2'd0, 16'h0, rdy, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 2'd0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1);
  endtask

  task automatic push_write(input logic [15:0] data, input logic [15:0] lo,
                            input logic [7:0] hi, input logic rdy);
    step(1'b1, 2'd0, data, rdy, 1'b0, 16'h0, 1'b0);
    step(1'b1, 2'd1, lo, rdy, 1'b0, 16'h0, 1'b0);
    step(1'b1, 2'd2, {8'h00, hi}, rdy, 1'b0, 16'h0, 1'b0);
  endtask

  // Monitor: every handshake pops the oldest predicted command and compares.
  initial begin
    cmd_t e;
    forever begin
      @(negedge c125m);
      if (!rst && bus.cmd_valid && bus.cmd_ready) begin
        if (sb.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL pop_unexpected: got addr %0h expected no command at %0t",
                   bus.cmd_addr, $time);
        end else begin
          e = sb.pop_front();
          chk("pop_addr", 32'(bus.cmd_addr), 32'(e.addr));
          chk("pop_data", 32'(bus.cmd_data), 32'(e.data));
          chk("pop_rw", 32'(bus.cmd_rw), 32'(e.rw));
          chk("pop_uds_n", 32'(bus.cmd_uds_n), 32'(e.uds_n));
          chk("pop_lds_n", 32'(bus.cmd_lds_n), 32'(e.lds_n));
        end
      end
    end
  end

  initial begin
    bus.wr_stb = 0; bus.wr_sa = 0; bus.wr_data = 0;
    bus.cmd_ready = 0; bus.rsp_valid = 0; bus.rsp_data = 0;
    do_reset();
    do_reset();

    // Full-word write assembly.
    push_write(16'hBEEF, 16'h1234, 8'h56, 1'b0);
    chk("t1_valid", 32'(bus.cmd_valid), 32'd1);
    chk("t1_addr", 32'(bus.cmd_addr), 32'h561234);
    chk("t1_data", 32'(bus.cmd_data), 32'hBEEF);
    chk("t1_rw", 32'(bus.cmd_rw), 32'd0);
    chk("t1_strobes", {30'd0, bus.cmd_uds_n, bus.cmd_lds_n}, 32'd0);
    chk("t1_busy", 32'(bus.txn_busy), 32'd1);
    idle(1'b1);

    // Byte read at an odd address, then its response.
    step(1'b1, 2'd1, 16'h0001, 1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b1, 2'd2, 16'h0300, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("t2_rw", 32'(bus.cmd_rw), 32'd1);
    chk("t2_uds_n", 32'(bus.cmd_uds_n), 32'd1);
    chk("t2_lds_n", 32'(bus.cmd_lds_n), 32'd0);
    idle(1'b1);
    chk("t2_busy_pending", 32'(bus.txn_busy), 32'd1);
    step(1'b0, 2'd0, 16'h0, 1'b0, 1'b1, 16'h00AB, 1'b0);
    chk("t2_rd_data", 32'(bus.rd_data), 32'h00AB);
    chk("t2_busy_done", 32'(bus.txn_busy), 32'd0);
    // A response with nothing outstanding is ignored.
    step(1'b0, 2'd0, 16'h0, 1'b0, 1'b1, 16'h5555, 1'b0);
    chk("t2_stray_rsp", 32'(bus.rd_data), 32'h00AB);

    // Overflow while stalled.
    do_reset();
    for (int i = 0; i <= DEPTH; i++) push_write(16'h1000 + 16'(i), 16'(i * 2), 8'h10, 1'b0);
    chk("t3_count", 32'(bus.fifo_count), DEPTH);
    chk("t3_err", 32'(bus.err), 32'd1);
    repeat (DEPTH + 1) idle(1'b1);

    // Push and pop together while full.
    do_reset();
    for (int i = 0; i < DEPTH; i++) push_write(16'h2000 + 16'(i), 16'h0100, 8'h20, 1'b0);
    step(1'b1, 2'd2, 16'h0021, 1'b1, 1'b0, 16'h0, 1'b0);
    chk("t4_count", 32'(bus.fifo_count), DEPTH);
    chk("t4_err", 32'(bus.err), 32'd0);
    repeat (DEPTH) idle(1'b1);

    // Second read rejected; read alongside a response accepted.
    do_reset();
    step(1'b1, 2'd2, 16'h0200, 1'b1, 1'b0, 16'h0, 1'b0);
    idle(1'b1);
    step(1'b1, 2'd2, 16'h0200, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("t5_reject_err", 32'(bus.err), 32'd1);
    chk("t5_reject_count", 32'(bus.fifo_count), 32'd0);
    step(1'b1, 2'd2, 16'h0201, 1'b0, 1'b1, 16'h1357, 1'b0);
    chk("t5_accept_count", 32'(bus.fifo_count), 32'd1);
    chk("t5_rd_data", 32'(bus.rd_data), 32'h1357);
    idle(1'b1);

    // Reset with commands queued and a read outstanding.
    do_reset();
    step(1'b1, 2'd2, 16'h0200, 1'b1, 1'b0, 16'h0, 1'b0);
    idle(1'b1);
    step(1'b0, 2'd0, 16'h0, 1'b0, 1'b1, 16'h00CD, 1'b0);
    step(1'b1, 2'd2, 16'h0200, 1'b1, 1'b0, 16'h0, 1'b0);
    idle(1'b1);
    for (int i = 0; i < 3; i++) push_write(16'h3000 + 16'(i), 16'h0, 8'h30, 1'b0);
    step(1'b1, 2'd2, 16'h0200, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("t6_pre_err", 32'(bus.err), 32'd1);
    step(1'b0, 2'd0, 16'h0, 1'b0, 1'b1, 16'hFFFF, 1'b1);
    chk("t6_count", 32'(bus.fifo_count), 32'd0);
    chk("t6_valid", 32'(bus.cmd_valid), 32'd0);
    chk("t6_busy", 32'(bus.txn_busy), 32'd0);
    chk("t6_err", 32'(bus.err), 32'd0);
    chk("t6_rd_data", 32'(bus.rd_data), 32'd0);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 4000; n++) begin
      logic       stb;
      logic [1:0] sa;
      stb = ($urandom_range(0, 9) < 7);
      sa  = ($urandom_range(0, 9) < 4) ? 2'd2 : 2'($urandom_range(0, 3));
      step(stb, sa, 16'($urandom), ($urandom_range(0, 9) < 5),
           ($urandom_range(0, 9) < 2), 16'($urandom), ($urandom_range(0, 499) == 0));
    end

    // Drain, with a bounded cycle budget.
    for (int n = 0; n < 40 && (m_cnt != 0 || m_pend); n++)
      step(1'b0, 2'd0, 16'h0, 1'b1, m_pend, 16'($urandom), 1'b0);
    @(negedge c125m);
    chk("drain_model_idle", 32'(m_cnt != 0 || m_pend), 32'd0);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
